mac_accumulator: RTL



---
 rtl/mac_pkg.sv | 18 +
 rtl/mac_accumulator_if.sv | 32 +++
 rtl/mul4x4_comb.sv | 12 +
 rtl/mac_accumulator.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/mac_pkg.sv
// Shared types and constants for the 4x4 multiply-accumulate slice.
package mac_pkg;

    localparam int OPND_W = 4;
    localparam int PROD_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        WAIT  = 2'd2
    } mac_state_t;

    // Width needed to hold a term count in the range 0..max_len.
    function automatic int count_w(input int max_len);
        return $clog2(max_len + 1);
    endfunction

endpackage

// File: rtl/mac_accumulator_if.sv
// Operand input channel and dot-product result channel of mac_accumulator.
interface mac_accumulator_if #(
    parameter int ACC_W   = 12,
    parameter int MAX_LEN = 16
);
    import mac_pkg::*;

    localparam int CNT_W = count_w(MAX_LEN);

    logic [OPND_W-1:0] a;
    logic [OPND_W-1:0] b;
    logic              in_valid;
    logic              in_last;
    logic              in_ready;
    logic [ACC_W-1:0]  out_data;
    logic [CNT_W-1:0]  out_count;
    logic              out_trunc;
    logic              out_ovf;
    logic              out_valid;
    logic              out_ready;

    modport master (
        output a, b, in_valid, in_last, out_ready,
        input  in_ready, out_data, out_count, out_trunc, out_ovf, out_valid
    );

    modport slave (
        input  a, b, in_valid, in_last, out_ready,
        output in_ready, out_data, out_count, out_trunc, out_ovf, out_valid
    );

endinterface

// File: rtl/mul4x4_comb.sv
// Purely combinational 4x4 -> 8 bit unsigned product feeding the S1 register.
module mul4x4_comb
    import mac_pkg::*;
(
    input  logic [OPND_W-1:0] a,
    input  logic [OPND_W-1:0] b,
    output logic [PROD_W-1:0] prod
);

    assign prod = PROD_W'(a) * PROD_W'(b);

endmodule

// File: rtl/mac_accumulator.sv
// Dot-product accumulator: S1 registers a*b, S2 sums one in_last-delimited vector.
// Build option: define MAC_SAT_EN to clamp the sum and report out_ovf; otherwise the sum wraps.
module mac_accumulator
    import mac_pkg::*;
#(
    parameter int ACC_W   = 12,
    parameter int MAX_LEN = 16
) (
    input logic              clk,
    input logic              rst,
    mac_accumulator_if.slave bus
);

    localparam int CNT_W = count_w(MAX_LEN);

    logic [PROD_W-1:0] prod_p0;
    logic [PROD_W-1:0] prod_p1;
    logic              last_p1;
    logic              vld_p1;

    mac_state_t        state;
    mac_state_t        state_nxt;
    logic [ACC_W-1:0]  acc;
    logic [CNT_W-1:0]  cnt;
    logic [ACC_W:0]    wide;
    logic [ACC_W-1:0]  sum;

    logic [ACC_W-1:0]  out_data_r;
    logic [CNT_W-1:0]  out_count_r;
    logic              out_trunc_r;
    logic              out_valid_r;

    logic              in_fire;
    logic              s1_take;
    logic              close_vec;

    function automatic logic [ACC_W:0] add_wide(input logic [ACC_W-1:0] x,
                                                input logic [PROD_W-1:0] p);
        return {1'b0, x} + (ACC_W+1)'(p);
    endfunction

    function automatic logic [ACC_W-1:0] limit(input logic [ACC_W:0] s);
`ifdef MAC_SAT_EN
        return s[ACC_W] ? {ACC_W{1'b1}} : s[ACC_W-1:0];
`else
        return s[ACC_W-1:0];
`endif
    endfunction

    mul4x4_comb u_mul (
        .a    (bus.a),
        .b    (bus.b),
        .prod (prod_p0)
    );

    // S1 drains whenever S2 is not parked in WAIT, so a new pair may enter behind it.
    assign bus.in_ready = !vld_p1 || (state != WAIT);
    assign in_fire      = bus.in_valid && bus.in_ready;
    assign s1_take      = vld_p1 && (state != WAIT);
    assign close_vec    = s1_take && (last_p1 || (int'(cnt) + 1 >= MAX_LEN));

    assign wide = add_wide(acc, prod_p1);
    assign sum  = limit(wide);

    // ---- stage S1: registered product ----
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1  <= 1'b0;
            last_p1 <= 1'b0;
            prod_p1 <= '0;
        end else if (in_fire) begin
            vld_p1  <= 1'b1;
            last_p1 <= bus.in_last;
            prod_p1 <= prod_p0;
        end else if (s1_take) begin
            vld_p1  <= 1'b0;
        end
    end

    // ---- stage S2: accumulate and present ----
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, ACCUM: if (s1_take) state_nxt = close_vec ? WAIT : ACCUM;
            WAIT:        if (bus.out_ready) state_nxt = IDLE;
            default:     state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc         <= '0;
            cnt         <= '0;
            out_data_r  <= '0;
            out_count_r <= '0;
            out_trunc_r <= 1'b0;
            out_valid_r <= 1'b0;
        end else if (s1_take) begin
            if (close_vec) begin
                out_data_r  <= sum;
                out_count_r <= cnt + CNT_W'(1);
                out_trunc_r <= !last_p1;
                out_valid_r <= 1'b1;
                acc         <= '0;
                cnt         <= '0;
            end else begin
                acc <= sum;
                cnt <= cnt + CNT_W'(1);
            end
        end else if (state == WAIT && bus.out_ready) begin
            out_valid_r <= 1'b0;
        end
    end

`ifdef MAC_SAT_EN
    logic ovf_acc;
    logic ovf_r;

    // Sticky within a vector; handed to the output when the vector closes.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_acc <= 1'b0;
            ovf_r   <= 1'b0;
        end else if (s1_take) begin
            if (close_vec) begin
                ovf_r   <= ovf_acc | wide[ACC_W];
                ovf_acc <= 1'b0;
            end else begin
                ovf_acc <= ovf_acc | wide[ACC_W];
            end
        end
    end

    assign bus.out_ovf = ovf_r;
`else
    assign bus.out_ovf = 1'b0;
`endif

    assign bus.out_data  = out_data_r;
    assign bus.out_count = out_count_r;
    assign bus.out_trunc = out_trunc_r;
    assign bus.out_valid = out_valid_r;

endmodule
